// File: rtl/stream_mux_arbiter_pkg.sv
// stream_mux_arbiter_pkg: shared encodings for the two-producer stream arbiter
package stream_mux_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic SRC_A = 1'b1;
    localparam logic SRC_B = 1'b0;
    localparam int DEFAULT_DATA_W = 16;

endpackage

// File: rtl/stream_mux_arbiter_mux.sv
// stream_mux_arbiter_mux: 2:1 data steering, sel high picks a
module stream_mux_arbiter_mux
    import stream_mux_arbiter_pkg::*;
#(
    parameter int W = DEFAULT_DATA_W
) (
    input  logic         reset,
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    // steer the selected input, forced to zero while reset is asserted
    always_comb y = reset ? '0 : (sel ? a : b);

endmodule

// File: rtl/stream_mux_arbiter.sv
// stream_mux_arbiter: round-robin burst arbiter sharing one registered output stream between A and B
module stream_mux_arbiter
    import stream_mux_arbiter_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int BURST_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_last,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_last,
    output logic              b_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_src,
    input  logic              out_ready,
    output logic              busy
);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  beat_cnt;
    logic              last_grant;
    logic              can_load, xfer, xfer_last, rel, sel;
    logic [DATA_W-1:0] mux_data;

    assign sel       = (state == GNT_A);
    assign can_load  = !out_valid || out_ready;
    assign a_ready   = sel && can_load;
    assign b_ready   = (state == GNT_B) && can_load;
    assign xfer      = (a_valid && a_ready) || (b_valid && b_ready);
    assign xfer_last = sel ? a_last : b_last;
    assign rel       = xfer && (xfer_last || (beat_cnt + CNT_W'(1)) == CNT_W'(BURST_LEN));
    assign busy      = (state != IDLE);

    stream_mux_arbiter_mux #(.W(DATA_W)) u_mux (
        .reset (1'b0),
        .sel   (sel),
        .a     (a_data),
        .b     (b_data),
        .y     (mux_data)
    );

    // arbitrate from IDLE, and on release hand over without a bubble; a count-limited burst
    // (no last yet) may keep the same side when the other side is idle
    always_comb begin
        state_nxt = state;
        if (state == IDLE)
            state_nxt = (a_valid && (!b_valid || last_grant == SRC_B)) ? GNT_A : (b_valid ? GNT_B : IDLE);
        else if (rel)
            state_nxt = sel ? (b_valid ? GNT_B : ((a_valid && !a_last) ? GNT_A : IDLE))
                            : (a_valid ? GNT_A : ((b_valid && !b_last) ? GNT_B : IDLE));
    end

    // grant state, burst beat counter and round-robin history
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            last_grant <= SRC_B;
        end else begin
            state <= state_nxt;
            if (rel) begin
                beat_cnt   <= '0;
                last_grant <= sel ? SRC_A : SRC_B;
            end else if (xfer) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    // output beat register: load on transfer, drain when downstream takes it
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_last  <= xfer_last;
            out_src   <= sel ? SRC_A : SRC_B;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
